// File: rtl/hqm_mem_sram_pg_seq.sv
// hqm_mem_sram_pg_seq: power-gated SRAM with staggered slice power-up,
// post-power-up clear, and a fixed-latency read pipeline.
module hqm_mem_sram_pg_seq #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 139,
  parameter int SLICE_W = 70,
  parameter int RD_LAT = 1,
  parameter int STAGGER = 4,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int AW = $clog2(DEPTH),
  localparam int SLICES = (WIDTH + SLICE_W - 1) / SLICE_W
) (
  input  logic              clk,
  input  logic              clk_rst_n,
  input  logic              re,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid,
  output logic              ready,
  output logic              access_err,
  input  logic              pgcb_isol_en,
  input  logic              pwr_enable_b_in,
  output logic              pwr_enable_b_out,
  output logic [SLICES-1:0] slice_pwr_on
);

  localparam int CW = $clog2(STAGGER + 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_PWRUP,
    S_INIT,
    S_READY,
    S_PWRDN
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   init_addr;
  logic            in_ready;
  logic            powered;
  logic            go_dn;
  logic            step;
  logic            flush;

  // The top slice's pad columns carry no data, so only WIDTH bits are kept.
  logic [WIDTH-1:0] mem [DEPTH];
  logic             init_wr;
  logic             rd_acc;
  logic             wr_acc;
  logic             wen;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wword;
  logic [WIDTH-1:0] rd_q;
  logic [RD_LAT:0]  rd_v;
  logic [WIDTH-1:0] rd_d [1:RD_LAT];

  assign powered = (state == S_PWRUP) || (state == S_INIT) ||
                   (state == S_READY);
  assign go_dn   = powered && pwr_enable_b_in;
  assign step    = (cnt == CW'(STAGGER - 1));
  assign flush   = (state == S_READY) && pwr_enable_b_in;

  assign ready   = in_ready & ~pgcb_isol_en;
  assign init_wr = (state == S_INIT);
  assign rd_acc  = re & ready;
  assign wr_acc  = we & ready;
  assign wen     = init_wr | wr_acc;
  assign waddr   = init_wr ? init_addr : addr;
  assign wword   = init_wr ? INIT_VAL : wdata;

  assign pwr_enable_b_out = ~&slice_pwr_on;
  assign rvalid = rd_v[RD_LAT] & ~pgcb_isol_en;
  assign rdata  = rvalid ? rd_d[RD_LAT] : '0;

  // Power sequencing and init sweep; slices power on low-to-high and off high-to-low.
  always_ff @(posedge clk or negedge clk_rst_n) begin
    if (!clk_rst_n) begin
      state        <= S_OFF;
      slice_pwr_on <= '0;
      cnt          <= '0;
      init_addr    <= '0;
      in_ready     <= 1'b0;
    end else if (go_dn) begin
      state        <= S_PWRDN;
      slice_pwr_on <= slice_pwr_on >> 1;
      cnt          <= '0;
      in_ready     <= 1'b0;
    end else begin
      unique case (state)
        S_OFF: begin
          if (!pwr_enable_b_in) begin
            state        <= S_PWRUP;
            slice_pwr_on <= SLICES'(1);
            cnt          <= '0;
          end
        end
        S_PWRUP: begin
          if (step) begin
            cnt <= '0;
            if (&slice_pwr_on) begin
              state     <= S_INIT;
              init_addr <= '0;
            end else begin
              slice_pwr_on <= (slice_pwr_on << 1) | SLICES'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_INIT: begin
          if (init_addr == AW'(DEPTH - 1)) begin
            state     <= S_READY;
            in_ready  <= 1'b1;
            init_addr <= '0;
          end else begin
            init_addr <= init_addr + AW'(1);
          end
        end
        S_READY: begin
        end
        S_PWRDN: begin
          if (step) begin
            cnt <= '0;
            if (|slice_pwr_on) begin
              slice_pwr_on <= slice_pwr_on >> 1;
            end else begin
              state <= S_OFF;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_OFF;
      endcase
    end
  end

  // Array port: read samples old contents before the same-edge write lands.
  always_ff @(posedge clk) begin
    if (wen) begin
      mem[waddr] <= wword;
    end
    if (rd_acc) begin
      rd_q <= mem[addr];
    end
  end

  // Read latency pipeline, emptied whenever the block leaves READY.
  always_ff @(posedge clk or negedge clk_rst_n) begin
    if (!clk_rst_n) begin
      rd_v <= '0;
      for (int i = 1; i <= RD_LAT; i++) begin
        rd_d[i] <= '0;
      end
    end else if (flush) begin
      rd_v <= '0;
    end else begin
      rd_v    <= {rd_v[RD_LAT-1:0], rd_acc};
      rd_d[1] <= rd_q;
      for (int i = 2; i <= RD_LAT; i++) begin
        rd_d[i] <= rd_d[i-1];
      end
    end
  end

  // Dropped-request flag, one cycle after the offending request.
  always_ff @(posedge clk or negedge clk_rst_n) begin
    if (!clk_rst_n) begin
      access_err <= 1'b0;
    end else begin
      access_err <= (re | we) & ~ready;
    end
  end

endmodule
